// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM states,
// data-bit-count encoding and frame helper functions.
package uart_pkg;

  localparam int DEFAULT_CLK_DIV_WIDTH = 16;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [2:0] last_data_idx(input logic [1:0] bits_code);
    logic [2:0] idx;
    case (bits_code)
      DATA_BITS_5: idx = 3'd4;
      DATA_BITS_6: idx = 3'd5;
      DATA_BITS_7: idx = 3'd6;
      DATA_BITS_8: idx = 3'd7;
      default:     idx = 3'd7;
    endcase
    return idx;
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] bits_code);
    logic [7:0] mask;
    case (bits_code)
      DATA_BITS_5: mask = 8'h1F;
      DATA_BITS_6: mask = 8'h3F;
      DATA_BITS_7: mask = 8'h7F;
      DATA_BITS_8: mask = 8'hFF;
      default:     mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Only the bits actually sent contribute; odd parity inverts the even result.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic [1:0] bits_code,
                                        input logic       odd);
    return (^(data & data_mask(bits_code))) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: loads a divisor, counts D-1 down to 0 and pulses
// tick_o in the last cycle of every bit while running.
module uart_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             run_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] load_val_s;

  // A divisor of 0 behaves as 1, so the reload value never underflows.
  assign load_val_s = (div_i == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : (div_i - WIDTH'(1));
  assign tick_o     = run_i && (cnt_q == {WIDTH{1'b0}});

  // Next-count selection: load, wrap to reload value, or count down.
  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      cnt_d    = load_val_s;
      reload_d = load_val_s;
    end else if (run_i) begin
      if (cnt_q == {WIDTH{1'b0}}) begin
        cnt_d = reload_q;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and reload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= {WIDTH{1'b0}};
      reload_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/uart_tx_reader.sv
// UART transmitter that pulls words from a TX FIFO and serialises them with
// configurable data bits, parity and stop bits; frames may run back to back.
module uart_tx_reader
  import uart_pkg::*;
#(
  parameter int CLK_DIV_WIDTH = DEFAULT_CLK_DIV_WIDTH,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_en_i,
  input  logic [CLK_DIV_WIDTH-1:0] cfg_clk_div_i,
  input  logic [1:0]               cfg_data_bits_i,
  input  logic                     cfg_parity_en_i,
  input  logic                     cfg_parity_odd_i,
  input  logic                     cfg_stop2_i,
  input  logic                     fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]    fifo_data_i,
  output logic                     fifo_pop_o,
  output logic                     tx_o,
  output logic                     busy_o
);

  tx_state_e  state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       run_q;
  logic [7:0] data_q, data_d;
  logic [1:0] bits_q, bits_d;
  logic       par_en_q, par_en_d;
  logic       par_q, par_d;
  logic       stop2_q, stop2_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_idx_q, stop_idx_d;

  logic [7:0] data8_s;
  logic       tick_s;
  logic       last_stop_s;
  logic       pop_s;

  if (DATA_WIDTH >= 8) begin : g_data_trunc
    assign data8_s = fifo_data_i[7:0];
  end else begin : g_data_ext
    assign data8_s = {{(8-DATA_WIDTH){1'b0}}, fifo_data_i};
  end

  // run_q keeps pops off while reset is held and for the first cycle after release.
  assign last_stop_s = (state_q == ST_STOP) && tick_s && (!stop2_q || stop_idx_q);
  assign pop_s       = run_q && cfg_en_i && !fifo_empty_i &&
                       ((state_q == ST_IDLE) || last_stop_s);

  uart_bit_timer #(
    .WIDTH (CLK_DIV_WIDTH)
  ) u_bit_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (pop_s),
    .div_i  (cfg_clk_div_i),
    .run_i  (busy_q),
    .tick_o (tick_s)
  );

  // Frame sequencing: latch a word on pop, then walk start/data/parity/stop.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    data_d     = data_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;

    if (pop_s) begin
      data_d     = data8_s;
      bits_d     = cfg_data_bits_i;
      par_en_d   = cfg_parity_en_i;
      par_d      = frame_parity(data8_s, cfg_data_bits_i, cfg_parity_odd_i);
      stop2_d    = cfg_stop2_i;
      bit_idx_d  = 3'd0;
      stop_idx_d = 1'b0;
      state_d    = ST_START;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
        ST_START: begin
          if (tick_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            tx_d      = data_q[0];
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (bit_idx_q == last_data_idx(bits_q)) begin
              if (par_en_q) begin
                state_d = ST_PARITY;
                tx_d    = par_q;
              end else begin
                state_d    = ST_STOP;
                stop_idx_d = 1'b0;
                tx_d       = 1'b1;
              end
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              tx_d      = data_q[bit_idx_q + 3'd1];
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (tick_s) begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP: begin
          if (tick_s) begin
            if (stop2_q && !stop_idx_q) begin
              stop_idx_d = 1'b1;
              tx_d       = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = ST_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, line driver and latched frame parameters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      run_q      <= 1'b0;
      data_q     <= 8'h00;
      bits_q     <= 2'd0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      run_q      <= 1'b1;
      data_q     <= data_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  assign fifo_pop_o = pop_s;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_reader.sv
// Scoreboard bench for uart_tx_reader: a FIFO model feeds words, expected
// line waveforms are queued on push and compared cycle by cycle after each pop.
module tb_uart_tx_reader;

  localparam int CDW = 16;
  localparam int DW  = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           cfg_en_i;
  logic [CDW-1:0] cfg_clk_div_i;
  logic [1:0]     cfg_data_bits_i;
  logic           cfg_parity_en_i;
  logic           cfg_parity_odd_i;
  logic           cfg_stop2_i;
  logic           fifo_empty_i;
  logic [DW-1:0]  fifo_data_i;
  logic           fifo_pop_o;
  logic           tx_o;
  logic           busy_o;

  typedef struct {
    logic [11:0] bits;
    int          n;
    int          d;
  } frame_t;

  int         errors  = 0;
  int         checks  = 0;
  int         cyc     = 0;
  int         pop_cnt = 0;
  logic [7:0] fifo_mem[$];
  frame_t     sb[$];

  uart_tx_reader #(.CLK_DIV_WIDTH(CDW), .DATA_WIDTH(DW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .cfg_en_i         (cfg_en_i),
    .cfg_clk_div_i    (cfg_clk_div_i),
    .cfg_data_bits_i  (cfg_data_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .fifo_empty_i     (fifo_empty_i),
    .fifo_data_i      (fifo_data_i),
    .fifo_pop_o       (fifo_pop_o),
    .tx_o             (tx_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic refresh();
    fifo_empty_i = (fifo_mem.size() == 0);
    fifo_data_i  = fifo_empty_i ? 8'h00 : fifo_mem[0];
  endtask

  // Advance one cycle (negedge to negedge); a pop seen in this cycle removes the FIFO head.
  task automatic step();
    logic p;
    p = fifo_pop_o;
    checks++;
    if (p && fifo_empty_i) begin
      errors++;
      $display("FAIL pop_when_empty: fifo_pop_o=1 with fifo_empty_i=1 at cycle %0d", cyc);
    end
    @(negedge clk_i);
    cyc++;
    if (p) begin
      pop_cnt++;
      if (fifo_mem.size() > 0) void'(fifo_mem.pop_front());
    end
    refresh();
  endtask

  function automatic frame_t make_frame(input logic [7:0] data, input logic [1:0] code,
                                        input logic pe, input logic po, input logic s2,
                                        input logic [CDW-1:0] div);
    frame_t f;
    int     ones;
    int     nb;
    f.bits    = 12'hFFF;
    f.bits[0] = 1'b0;
    f.n       = 1;
    ones      = 0;
    nb        = 5 + int'(code);
    for (int i = 0; i < nb; i++) begin
      f.bits[f.n] = data[i];
      if (data[i]) ones++;
      f.n++;
    end
    if (pe) begin
      f.bits[f.n] = ((ones % 2) == 1) ^ po;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    f.d = (div == '0) ? 1 : int'(div);
    return f;
  endfunction

  task automatic set_cfg(input logic en, input logic [1:0] code, input logic pe,
                         input logic po, input logic s2, input logic [CDW-1:0] div);
    cfg_en_i         = en;
    cfg_data_bits_i  = code;
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
    cfg_clk_div_i    = div;
  endtask

  task automatic push(input logic [7:0] data, input bit expect_frame);
    fifo_mem.push_back(data);
    if (expect_frame)
      sb.push_back(make_frame(data, cfg_data_bits_i, cfg_parity_en_i,
                              cfg_parity_odd_i, cfg_stop2_i, cfg_clk_div_i));
    refresh();
  endtask

  // Wait for a pop (unless already chained), then compare every cycle of the frame.
  task automatic run_frame(input string name, input bit chained, input int drop_en_at,
                           input bit scramble, output int pop_cyc, output bit next_chained);
    frame_t f;
    int     w;
    next_chained = 1'b0;
    pop_cyc      = -1;
    if (!chained) begin
      w = 0;
      while (!fifo_pop_o && w < 300) begin
        step();
        w++;
      end
      checks++;
      if (!fifo_pop_o) begin
        errors++;
        $display("FAIL %s_pop_timeout: no fifo_pop_o within 300 cycles, required a pop", name);
        return;
      end
      pop_cyc = cyc;
      step();
    end else begin
      pop_cyc = cyc - 1;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: pop seen with 0 expected frames, required 1", name);
      return;
    end
    f = sb.pop_front();
    if (scramble) begin
      cfg_clk_div_i    = 16'd9;
      cfg_data_bits_i  = 2'd0;
      cfg_parity_en_i  = ~cfg_parity_en_i;
      cfg_stop2_i      = ~cfg_stop2_i;
    end
    for (int b = 0; b < f.n; b++) begin
      for (int k = 0; k < f.d; k++) begin
        if (b == drop_en_at && k == 0) cfg_en_i = 1'b0;
        checks++;
        if (tx_o !== f.bits[b] || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL %s_bit%0d_c%0d: tx_o=%b busy_o=%b, required tx_o=%b busy_o=1",
                   name, b, k, tx_o, busy_o, f.bits[b]);
        end
        if (b == f.n - 1 && k == f.d - 1) next_chained = fifo_pop_o;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    set_cfg(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    refresh();
    repeat (3) step();
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx_o=%b busy_o=%b pop=%b, required 1 0 0", tx_o, busy_o, fifo_pop_o);
    end
    rst_ni = 1'b1;
    repeat (3) step();
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_8n1();
    int pc;
    bit nc;
    int p0;
    p0 = pop_cnt;
    set_cfg(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    push(8'h55, 1'b1);
    run_frame("8n1", 1'b0, -1, 1'b1, pc, nc);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_end_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
    checks++;
    if (pop_cnt != p0 + 1) begin
      errors++;
      $display("FAIL 8n1_pop_count: %0d pops, required 1", pop_cnt - p0);
    end
  endtask

  task automatic test_parity();
    int pc;
    bit nc;
    set_cfg(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 16'd2);
    push(8'h07, 1'b1);
    run_frame("7e1", 1'b0, -1, 1'b0, pc, nc);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL 7e1_end_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
    set_cfg(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2);
    push(8'h07, 1'b1);
    run_frame("7o1", 1'b0, -1, 1'b0, pc, nc);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL 7o1_end_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int pc1;
    int pc2;
    bit nc1;
    bit nc2;
    set_cfg(1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 16'd3);
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    run_frame("b2b_first", 1'b0, -1, 1'b0, pc1, nc1);
    checks++;
    if (nc1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_chain_pop: pop in final stop cycle=%b, required 1", nc1);
    end
    run_frame("b2b_second", nc1, -1, 1'b0, pc2, nc2);
    checks++;
    if (pc2 - pc1 != 33) begin
      errors++;
      $display("FAIL b2b_pop_spacing: pops %0d cycles apart, required 33", pc2 - pc1);
    end
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_div0();
    int pc;
    bit nc;
    set_cfg(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    push(8'h1F, 1'b1);
    run_frame("div0", 1'b0, -1, 1'b0, pc, nc);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL div0_end_idle: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
  endtask

  task automatic test_empty_disable();
    int pc;
    bit nc;
    int p0;
    p0 = pop_cnt;
    set_cfg(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 16'd2);
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle_c%0d: tx_o=%b busy_o=%b pop=%b, required 1 0 0",
                 i, tx_o, busy_o, fifo_pop_o);
      end
      step();
    end
    push(8'h96, 1'b1);
    push(8'h11, 1'b0);
    run_frame("disable_mid", 1'b0, 3, 1'b0, pc, nc);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL disabled_idle_c%0d: tx_o=%b busy_o=%b, required 1 0", i, tx_o, busy_o);
      end
      step();
    end
    checks++;
    if (pop_cnt != p0 + 1 || fifo_mem.size() != 1) begin
      errors++;
      $display("FAIL disable_pop_count: %0d pops, %0d words left, required 1 pop and 1 word",
               pop_cnt - p0, fifo_mem.size());
    end
    fifo_mem.delete();
    refresh();
  endtask

  task automatic test_reset_mid();
    int pc;
    bit nc;
    int w;
    int p0;
    set_cfg(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    push(8'h5A, 1'b0);
    w = 0;
    while (!fifo_pop_o && w < 50) begin
      step();
      w++;
    end
    checks++;
    if (!fifo_pop_o) begin
      errors++;
      $display("FAIL rstmid_pop_timeout: no pop within 50 cycles, required a pop");
    end
    repeat (13) step();
    push(8'hC3, 1'b1);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: tx_o=%b busy_o=%b pop=%b, required 1 0 0", tx_o, busy_o, fifo_pop_o);
    end
    p0 = pop_cnt;
    repeat (3) step();
    rst_ni = 1'b1;
    run_frame("rst_restart", 1'b0, -1, 1'b0, pc, nc);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || pop_cnt != p0 + 1) begin
      errors++;
      $display("FAIL rstmid_after: tx_o=%b busy_o=%b pops=%0d, required 1 0 1",
               tx_o, busy_o, pop_cnt - p0);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    set_cfg(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 16'd4);
    refresh();
    @(negedge clk_i);
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_div0();
    test_empty_disable();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never sent, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_reader.md
UART_TX_READER -- requirements
Module: uart_tx_reader

Interface
REQ-001 SHALL have parameter CLK_DIV_WIDTH, default 16, giving the width of the baud divisor input.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the width of the FIFO data word; frames carry at most 8 bits.
REQ-003 SHALL have one clock, clk_i; reset rst_ni is asynchronous, active-low.
REQ-004 SHALL have the following ports, each given as name, direction, width, meaning:
- clk_i  in  1  clock.
- rst_ni  in  1  async active-low reset.
- cfg_en_i  in  1  transmitter enable.
- cfg_clk_div_i  in  CLK_DIV_WIDTH  clocks per bit; 0 is treated as 1.
- cfg_data_bits_i  in  2  data bits: 0=5, 1=6, 2=7, 3=8.
- cfg_parity_en_i  in  1  append a parity bit.
- cfg_parity_odd_i  in  1  1=odd parity, 0=even parity.
- cfg_stop2_i  in  1  1=two stop bits, 0=one stop bit.
- fifo_empty_i  in  1  empty flag from the TX FIFO.
- fifo_data_i  in  DATA_WIDTH  head-of-FIFO word; valid whenever fifo_empty_i=0.
- fifo_pop_o  out  1  single-cycle pop strobe to the FIFO.
- tx_o  out  1  serial line; idle high.
- busy_o  out  1  a frame is in progress.

Function
REQ-005 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-006 SHALL, in IDLE with cfg_en_i=1 and fifo_empty_i=0, assert fifo_pop_o for exactly one cycle (cycle N). In that same cycle it SHALL latch fifo_data_i and all cfg_* inputs.
REQ-007 SHALL drive tx_o low (start bit) from cycle N+1 and set busy_o=1 from N+1.
REQ-008 SHALL hold each bit for D cycles, where D = max(cfg_clk_div_i,1) latched at the pop.
REQ-009 SHALL send data bits LSB first, only the configured count (5..8).
REQ-010 SHALL, when parity is enabled, send the parity bit after the data bits. The parity bit is the XOR of the sent data bits, inverted if odd parity is selected.
REQ-011 SHALL send 1 or 2 stop bits high, each D cycles.
REQ-012 SHALL give a frame length of (1 + bits + parity + stop) x D cycles.
REQ-013 SHALL, in the last cycle of the final stop bit with cfg_en_i=1 and fifo_empty_i=0, pop again. The next start bit SHALL begin on the following cycle with no idle gap and busy_o held at 1.
REQ-014 SHALL otherwise return to IDLE after the final stop bit, with tx_o=1 and busy_o=0.
REQ-015 SHALL complete the current frame if cfg_en_i deasserts mid-frame, then stay in IDLE.
REQ-016 SHALL ignore cfg_* changes mid-frame; they take effect at the next pop.
REQ-017 SHALL never assert fifo_pop_o while fifo_empty_i=1, and never outside IDLE or the final stop cycle.
REQ-018 SHALL register tx_o so it is glitch-free.
REQ-019 SHALL implement the bit-timer counter with width CLK_DIV_WIDTH, counting D-1 down to 0, with no overflow for any divisor value.

Reset
REQ-020 SHALL, on rst_ni=0, immediately (asynchronously) set the state to IDLE, tx_o=1, busy_o=0, fifo_pop_o=0, and clear all counters and latches.
REQ-021 SHALL abandon a frame if reset asserts mid-frame; that byte is not resent after reset.

Structure
REQ-022 SHALL place the following in shared package uart_pkg: the state enum, the data-bits encoding constants and the default CLK_DIV_WIDTH.
REQ-023 SHALL use sub-module uart_bit_timer (divisor load, bit-end tick) for bit timing; all other logic is in uart_tx_reader.

Verification
REQ-024 8N1, D=4, FIFO holds 0x55 -> one pop pulse; tx_o = 0,1,0,1,0,1,0,1,0,1, each 4 cycles; frame 40 cycles; busy_o=1 for exactly 40 cycles.
REQ-025 7E1, D=2, data 0x07 -> tx_o = 0,1,1,1,0,0,0,0, then parity 1, then stop 1; 20 cycles total. The same data with odd parity -> parity bit 0.
REQ-026 Back-to-back: 8N2, D=3, FIFO holds 0xA5 and 0x3C -> pops 33 cycles apart; the second start bit directly follows the last stop bit; busy_o never drops between frames.
REQ-027 cfg_clk_div_i=0, 5N1, data 0x1F -> each bit lasts 1 cycle; frame 7 cycles.
REQ-028 fifo_empty_i=1, cfg_en_i=1 for 100 cycles -> no pop, tx_o=1, busy_o=0. Then deassert cfg_en_i during the 3rd data bit -> the frame completes and no further pop occurs.
REQ-029 Assert rst_ni=0 during a data bit -> tx_o=1 and busy_o=0 within the same cycle. After release with the FIFO non-empty -> a new pop, and the frame starts cleanly.
